// File: rtl/microseq.sv
// Microprogram sequencer: next control-store address generation
// with dispatch, conditional branch and a micro-subroutine stack.
module microseq #(
    parameter int              AW         = 5,
    parameter int              DEPTH      = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 seqop,
    input  logic [1:0]                 condsel,
    input  logic [AW-1:0]              dbin,
    input  logic [AW-1:0]              ibin,
    input  logic [AW-1:0]              sbin,
    input  logic [3:0]                 cc,
    input  logic                       stall,
    output logic [AW-1:0]              nextst,
    output logic [AW-1:0]              upc,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf,
    output logic                       udf
);

    localparam int SW = $clog2(DEPTH);

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_JUMP  = 3'b001;
    localparam logic [2:0] OP_DISPI = 3'b010;
    localparam logic [2:0] OP_DISPS = 3'b011;
    localparam logic [2:0] OP_BRT   = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_HOLD  = 3'b111;

    localparam logic [SW:0] SP_FULL = (SW+1)'(DEPTH);
    localparam logic [SW:0] SP_ONE  = (SW+1)'(1);

    logic [AW-1:0] stack [DEPTH];
    logic [SW:0]   sp;
    logic [AW-1:0] inc;
    logic [SW-1:0] top;
    logic [1:0]    cidx;
    logic          cond;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          oflow;
    logic          uflow;

    assign inc   = upc + AW'(1);
    assign top   = sp[SW-1:0] - SW'(1);
    assign cidx  = 2'd3 - condsel;
    assign cond  = cc[cidx];
    assign full  = (sp == SP_FULL);
    assign empty = (sp == '0);
    assign depth = sp;

    always_comb begin
        nextst = upc;
        push   = 1'b0;
        pop    = 1'b0;
        oflow  = 1'b0;
        uflow  = 1'b0;
        if (reset) begin
            nextst = RESET_ADDR;
        end else if (!stall) begin
            unique case (seqop)
                OP_NEXT:  nextst = inc;
                OP_JUMP:  nextst = dbin;
                OP_DISPI: nextst = ibin;
                OP_DISPS: nextst = sbin;
                OP_BRT:   nextst = cond ? dbin : inc;
                OP_CALL: begin
                    nextst = dbin;
                    oflow  = full;
                    push   = !full;
                end
                OP_RET: begin
                    // An empty-stack return restarts the microprogram.
                    nextst = empty ? RESET_ADDR : stack[top];
                    uflow  = empty;
                    pop    = !empty;
                end
                OP_HOLD:  nextst = upc;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upc <= RESET_ADDR;
            sp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            upc <= nextst;
            ovf <= ovf | oflow;
            udf <= udf | uflow;
            if (push)
                sp <= sp + SP_ONE;
            else if (pop)
                sp <= sp - SP_ONE;
        end
    end

    // Stack contents need no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (!reset && push)
            stack[sp[SW-1:0]] <= inc;
    end

endmodule

// File: tb/tb_microseq.sv
// Randomized self-checking bench for microseq against a
// queue-based reference model of the sequencer.
module tb_microseq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] seqop = '0;
    logic [1:0] condsel = '0;
    logic [4:0] dbin = '0;
    logic [4:0] ibin = '0;
    logic [4:0] sbin = '0;
    logic [3:0] cc = '0;
    logic       stall = 1'b0;
    logic [4:0] nextst;
    logic [4:0] upc;
    logic [2:0] depth;
    logic       ovf;
    logic       udf;

    int vectors = 0;
    int errors  = 0;

    int m_upc;
    int m_ovf;
    int m_udf;
    int rs[$];

    microseq #(.AW(5), .DEPTH(4), .RESET_ADDR(5'd0)) dut (
        .clock(clock), .reset(reset), .seqop(seqop),
        .condsel(condsel), .dbin(dbin), .ibin(ibin),
        .sbin(sbin), .cc(cc), .stall(stall),
        .nextst(nextst), .upc(upc), .depth(depth),
        .ovf(ovf), .udf(udf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int op, input int cs,
                                      input int d, input int i,
                                      input int s, input int c,
                                      input int st, input int rst);
        int inc;
        inc = (m_upc + 1) % 32;
        if (rst != 0) return 0;
        if (st != 0) return m_upc;
        case (op)
            0: return inc;
            1: return d;
            2: return i;
            3: return s;
            4: return ((c >> (3 - cs)) & 1) != 0 ? d : inc;
            5: return d;
            6: return rs.size() > 0 ? rs[$] : 0;
            default: return m_upc;
        endcase
    endfunction

    task automatic step(input int op, input int cs, input int d,
                        input int i, input int s, input int c,
                        input int st, input int rst);
        int exp;
        seqop   = 3'(op);
        condsel = 2'(cs);
        dbin    = 5'(d);
        ibin    = 5'(i);
        sbin    = 5'(s);
        cc      = 4'(c);
        stall   = st[0];
        reset   = rst[0];
        @(negedge clock);
        exp = model_next(op, cs, d, i, s, c, st, rst);
        chk("nextst", nextst, exp);
        chk("upc", upc, m_upc);
        chk("depth", depth, rs.size());
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        @(posedge clock);
        #1;
        if (rst != 0) begin
            m_upc = 0;
            m_ovf = 0;
            m_udf = 0;
            rs.delete();
        end else begin
            if (st == 0 && op == 5) begin
                if (rs.size() < 4) rs.push_back((m_upc + 1) % 32);
                else m_ovf = 1;
            end
            if (st == 0 && op == 6) begin
                if (rs.size() > 0) void'(rs.pop_back());
                else m_udf = 1;
            end
            m_upc = exp;
        end
    endtask

    task automatic go(input int op, input int d);
        step(op, 0, d, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clock);
        #1;
        m_upc = 0;
        m_ovf = 0;
        m_udf = 0;
        rs.delete();

        step(1, 0, 5'h1F, 0, 0, 0, 0, 1);
        step(1, 0, 5'h1F, 0, 0, 0, 0, 1);
        go(0, 0);
        go(0, 0);
        go(0, 0);
        chk("count_upc", upc, 3);

        step(2, 0, 0, 5'h12, 0, 0, 0, 0);
        chk("dispi_upc", upc, 5'h12);
        step(3, 0, 0, 0, 5'h07, 0, 0, 0);
        chk("disps_upc", upc, 5'h07);

        go(1, 4);
        step(4, 0, 5'h0A, 0, 0, 4'b1000, 0, 0);
        chk("brt_taken", upc, 5'h0A);
        go(1, 4);
        step(4, 0, 5'h0A, 0, 0, 4'b0111, 0, 0);
        chk("brt_not", upc, 5);

        go(1, 2);
        go(5, 5'h10);
        go(5, 5'h18);
        chk("nest_depth", depth, 2);
        go(6, 0);
        chk("ret1_upc", upc, 5'h11);
        go(6, 0);
        chk("ret2_upc", upc, 3);

        for (int k = 0; k < 5; k++) go(5, 4 * k + 1);
        chk("ovf_depth", depth, 4);
        chk("ovf_set", ovf, 1);
        for (int k = 0; k < 5; k++) go(6, 0);
        chk("udf_upc", upc, 0);
        chk("udf_set", udf, 1);
        go(0, 0);
        go(1, 5'h1F);
        go(0, 0);
        chk("wrap_upc", upc, 0);
        chk("ovf_sticky", ovf, 1);
        chk("udf_sticky", udf, 1);

        for (int k = 0; k < 3; k++) step(5, 0, 5'h14, 0, 0, 0, 1, 0);
        chk("stall_upc", upc, 0);
        chk("stall_depth", depth, 0);
        step(5, 0, 5'h14, 0, 0, 0, 0, 0);
        chk("call_once", depth, 1);
        chk("call_upc", upc, 5'h14);

        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_depth", depth, 0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(7), $urandom_range(3),
                 $urandom_range(31), $urandom_range(31),
                 $urandom_range(31), $urandom_range(15),
                 ($urandom_range(7) == 0) ? 1 : 0,
                 ($urandom_range(49) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
